// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display path: the digit type,
// the blank code and the 16-entry active-low segment table {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low segment codes for digit values 0..15.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder. In decimal builds the values 10..15
// can never reach this block, but they still decode to blank.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int COUNT_BASE = 10
) (
  input  digit_t     i_value,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);

  // Table lookup, overridden by explicit blanking or an out-of-radix value.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    o_seg_n = SEG_LUT[i_value];
    if (i_blank || ((COUNT_BASE == 10) && (i_value > 4'd9))) begin
      o_seg_n = SEG_BLANK;
    end
  end

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// Multi-digit up/down counter (radix 10 or 16) with a synchronised step input
// and a time-multiplexed, common-anode 7-segment display driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_counter_7seg_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int COUNT_BASE = 10,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_in,
  input  logic                    up_dn,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] count_out,
  output logic                    wrap_pulse,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n
);

  localparam int     IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int     CNT_W     = $clog2(SCAN_DIV);
  localparam digit_t DIGIT_MAX = digit_t'(COUNT_BASE - 1);

  logic                         r_sync1, r_sync2, r_sync3, r_step;
  digit_t [NUM_DIGITS-1:0]      r_count;
  logic                         r_wrap;
  logic [CNT_W-1:0]             r_scan_cnt;
  logic [IDX_W-1:0]             r_scan_idx;
  logic [6:0]                   r_seg_n;
  logic [NUM_DIGITS-1:0]        r_an_n;

  digit_t [NUM_DIGITS-1:0]      w_next;
  logic                         w_carry;
  logic                         w_blank;
  logic [6:0]                   w_seg_n;

  // Two-flop synchroniser, previous-value flop and registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_step  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_sync1 <= step_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_step  <= r_sync2 & ~r_sync3;
    end
  end

  // Ripple carry/borrow across all digits within one cycle; w_carry out of the
  // top digit means the whole count wrapped.
  always_comb begin
    w_next  = r_count;
    w_carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_carry) begin
        if (up_dn) begin
          if (r_count[i] == DIGIT_MAX) begin
            w_next[i] = '0;
          end else begin
            w_next[i] = r_count[i] + digit_t'(1);
            w_carry   = 1'b0;
          end
        end else begin
          if (r_count[i] == '0) begin
            w_next[i] = DIGIT_MAX;
          end else begin
            w_next[i] = r_count[i] - digit_t'(1);
            w_carry   = 1'b0;
          end
        end
      end
    end
  end

  // Count register; clear has priority over a step and suppresses the wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (r_step) begin
      r_count <= w_next;
      r_wrap  <= w_carry;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Scan timer: each digit owns SCAN_DIV cycles, then the index moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
    end else if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_scan_idx <= (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lead_zero;

  // w_lead_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    w_lead_zero                 = '0;
    w_lead_zero[NUM_DIGITS-1]   = (r_count[NUM_DIGITS-1] == '0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_lead_zero[i] = w_lead_zero[i+1] && (r_count[i] == '0);
    end
  end

  assign w_blank = (r_scan_idx != '0) && w_lead_zero[r_scan_idx];
`else
  assign w_blank = 1'b0;
`endif

  seg7_decode #(
    .COUNT_BASE (COUNT_BASE)
  ) u_decode (
    .i_value (r_count[r_scan_idx]),
    .i_blank (w_blank),
    .o_seg_n (w_seg_n)
  );

  // Segments and anode registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n <= SEG_BLANK;
      r_an_n  <= '1;
    end else begin
      r_seg_n <= w_seg_n;
      r_an_n  <= ~(NUM_DIGITS'(1) << r_scan_idx);
    end
  end

  assign count_out  = r_count;
  assign wrap_pulse = r_wrap;
  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// Directed self-checking bench: a decimal 4-digit instance and a hex 4-digit
// instance, both with SCAN_DIV=4.
module tb_bcd_counter_7seg_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_in, step_h, up_dn, clr;
  logic [15:0] count_out, count_h;
  logic        wrap_pulse, wrap_h;
  logic [6:0]  seg_n, seg_h;
  logic [3:0]  an_n, an_h;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_counter_7seg_mux #(.NUM_DIGITS(4), .COUNT_BASE(10), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .step_in(step_in), .up_dn(up_dn), .clr(clr),
    .count_out(count_out), .wrap_pulse(wrap_pulse), .seg_n(seg_n), .an_n(an_n)
  );

  bcd_counter_7seg_mux #(.NUM_DIGITS(4), .COUNT_BASE(16), .SCAN_DIV(4)) dut_hex (
    .clk(clk), .rst_n(rst_n), .step_in(step_h), .up_dn(up_dn), .clr(clr),
    .count_out(count_h), .wrap_pulse(wrap_h), .seg_n(seg_h), .an_n(an_h)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One step request on the chosen instance; returns the wrap pulses seen.
  task automatic do_step(input logic dir, input int hold, input bit hex, output int wraps);
    wraps = 0;
    up_dn = dir;
    if (hex) step_h = 1'b1; else step_in = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      wraps += hex ? int'(wrap_h) : int'(wrap_pulse);
    end
    step_in = 1'b0;
    step_h  = 1'b0;
    repeat (4) begin
      @(negedge clk);
      wraps += hex ? int'(wrap_h) : int'(wrap_pulse);
    end
  endtask

  task automatic steps(input logic dir, input int n, input bit hex);
    int w;
    for (int i = 0; i < n; i++) do_step(dir, 5, hex, w);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Align to the first negedge of the digit-0 slot; bounded wait.
  task automatic sync_slot0(input bit hex);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if ((hex ? an_h : an_n) == 4'b0111) found = 1;
    end
    check("scan_sync_last", {31'd0, found}, 32'd1);
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if ((hex ? an_h : an_n) == 4'b1110) found = 1;
    end
    check("scan_sync_first", {31'd0, found}, 32'd1);
  endtask

  initial begin : stim
    int w;
    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic [6:0] hex_seg [4];

    rst_n = 1'b0; step_in = 1'b0; step_h = 1'b0; up_dn = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count_out), 32'h0);
    check("rst_wrap",  32'(wrap_pulse), 32'h0);
    check("rst_seg",   32'(seg_n), 32'h7F);
    check("rst_an",    32'(an_n), 32'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Down from 0000 wraps to 9999, then 9998; up back through 9999 to 0000.
    do_step(1'b0, 5, 0, w);
    check("dn_wrap_count", 32'(count_out), 32'h9999);
    check("dn_wrap_pulse", 32'(w), 32'd1);
    do_step(1'b0, 5, 0, w);
    check("preload_9998", 32'(count_out), 32'h9998);
    do_step(1'b1, 5, 0, w);
    check("up_9999", 32'(count_out), 32'h9999);
    check("up_9999_nowrap", 32'(w), 32'd0);
    do_step(1'b1, 5, 0, w);
    check("up_wrap_count", 32'(count_out), 32'h0000);
    check("up_wrap_pulse", 32'(w), 32'd1);

    // Borrow across two digits.
    steps(1'b1, 100, 0);
    check("preload_0100", 32'(count_out), 32'h0100);
    do_step(1'b0, 5, 0, w);
    check("borrow_0099", 32'(count_out), 32'h0099);
    check("borrow_nowrap", 32'(w), 32'd0);

    pulse_clr();
    check("clr_count", 32'(count_out), 32'h0);

    // Level held high for 20 cycles counts once.
    do_step(1'b1, 20, 0, w);
    check("hold_one_step", 32'(count_out), 32'h0001);
    steps(1'b1, 4, 0);
    check("preload_0005", 32'(count_out), 32'h0005);

    // clr lands on the same edge the step would update the count.
    w = 0;
    up_dn = 1'b1;
    step_in = 1'b1;
    repeat (3) begin @(negedge clk); w += int'(wrap_pulse); end
    clr = 1'b1;
    @(negedge clk); w += int'(wrap_pulse);
    clr = 1'b0;
    repeat (6) begin @(negedge clk); w += int'(wrap_pulse); end
    step_in = 1'b0;
    repeat (4) begin @(negedge clk); w += int'(wrap_pulse); end
    check("clr_prio_count", 32'(count_out), 32'h0000);
    check("clr_prio_nowrap", 32'(w), 32'd0);

    // Reset in the middle of a scan slot.
    steps(1'b1, 42, 0);
    check("preload_0042", 32'(count_out), 32'h0042);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(count_out), 32'h0);
    check("midrst_seg",   32'(seg_n), 32'h7F);
    check("midrst_an",    32'(an_n), 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_slot0", 32'(an_n), 32'hE);

    // Scan of 1234.
    steps(1'b1, 1234, 0);
    check("preload_1234", 32'(count_out), 32'h1234);
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    sync_slot0(0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("scan_an_%0d", i), 32'(an_n), 32'(exp_an[i/4]));
      check($sformatf("scan_seg_%0d", i), 32'(seg_n), 32'(exp_seg[i/4]));
      @(negedge clk);
    end

    // Hex instance at 0x00A0.
    steps(1'b1, 160, 1);
    check("hex_count_00A0", 32'(count_h), 32'h00A0);
`ifdef LEADING_ZERO_BLANK_EN
    hex_seg = '{7'b1000000, 7'b0001000, 7'b1111111, 7'b1111111};
`else
    hex_seg = '{7'b1000000, 7'b0001000, 7'b1000000, 7'b1000000};
`endif
    sync_slot0(1);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("hex_an_%0d", s),  32'(an_h),  32'(exp_an[s]));
      check($sformatf("hex_seg_%0d", s), 32'(seg_h), 32'(hex_seg[s]));
      repeat (3) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
